// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//
// Raster timing generator for VGA/SVGA displays. Two free-running counters
// (h_cnt, v_cnt) walk the raster one position per pixel tick; an output
// stage registers the position together with the sync, blanking and strobe
// signals decoded from it, so every output refers to the same (x,y) on the
// same clk.
//
// Ports
//   clk          in   system clock, single domain
//   rst          in   asynchronous active-high reset
//   pix_en       in   pixel tick; raster advances only when high
//   en           in   run enable; low forces idle (counters and outputs cleared)
//   hsync        out  horizontal sync, active level H_SYNC_POL
//   vsync        out  vertical sync, active level V_SYNC_POL
//   video_on     out  current pixel lies in the active area
//   pixel_x      out  horizontal position of the current pixel
//   pixel_y      out  vertical position of the current pixel
//   line_start   out  one-clk strobe at x=0
//   frame_start  out  one-clk strobe at (0,0)
//   vblank_start out  one-clk strobe at (0,V_LINES)
//   frame_count  out  number of frame_start strobes, wrapping

module vga_timing_gen #(
    parameter int H_PIXELS     = 800,
    parameter int H_FRONTPORCH = 40,
    parameter int H_SYNCTIME   = 128,
    parameter int H_BACKPORCH  = 88,
    parameter int V_LINES      = 600,
    parameter int V_FRONTPORCH = 1,
    parameter int V_SYNCTIME   = 4,
    parameter int V_BACKPORCH  = 23,
    parameter bit H_SYNC_POL   = 1'b1,
    parameter bit V_SYNC_POL   = 1'b1,
    parameter int CNT_BITS     = 12,
    parameter int FRAME_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    input  logic                  en,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  video_on,
    output logic [CNT_BITS-1:0]   pixel_x,
    output logic [CNT_BITS-1:0]   pixel_y,
    output logic                  line_start,
    output logic                  frame_start,
    output logic                  vblank_start,
    output logic [FRAME_BITS-1:0] frame_count
);

    localparam int H_TOTAL = H_PIXELS + H_FRONTPORCH + H_SYNCTIME + H_BACKPORCH;
    localparam int V_TOTAL = V_LINES + V_FRONTPORCH + V_SYNCTIME + V_BACKPORCH;

    localparam logic [CNT_BITS-1:0] H_MAX        = CNT_BITS'(H_TOTAL - 1);
    localparam logic [CNT_BITS-1:0] V_MAX        = CNT_BITS'(V_TOTAL - 1);
    localparam logic [CNT_BITS-1:0] H_ACT_END    = CNT_BITS'(H_PIXELS);
    localparam logic [CNT_BITS-1:0] V_ACT_END    = CNT_BITS'(V_LINES);
    localparam logic [CNT_BITS-1:0] H_SYNC_START = CNT_BITS'(H_PIXELS + H_FRONTPORCH);
    localparam logic [CNT_BITS-1:0] H_SYNC_END   = CNT_BITS'(H_PIXELS + H_FRONTPORCH + H_SYNCTIME);
    localparam logic [CNT_BITS-1:0] V_SYNC_START = CNT_BITS'(V_LINES + V_FRONTPORCH);
    localparam logic [CNT_BITS-1:0] V_SYNC_END   = CNT_BITS'(V_LINES + V_FRONTPORCH + V_SYNCTIME);
    localparam logic [CNT_BITS-1:0] CNT_ZERO     = '0;
    localparam logic [FRAME_BITS-1:0] FRAME_ONE  = FRAME_BITS'(1);

    logic [CNT_BITS-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_BITS-1:0] v_cnt_q, v_cnt_d;
    logic                h_wrap;
    logic                h_sync_act, v_sync_act, active_d;
    logic                line_start_d, frame_start_d, vblank_start_d;

    // Next raster position and decode of the current one. The output stage
    // registers the decode of h_cnt_q/v_cnt_q, not of the next position, so
    // pixel_x/pixel_y and every flag describe the same pixel.
    always_comb begin
        h_wrap  = (h_cnt_q == H_MAX);
        h_cnt_d = h_wrap ? CNT_ZERO : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_MAX) ? CNT_ZERO : v_cnt_q + 1'b1;
        end

        h_sync_act     = (h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END);
        v_sync_act     = (v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END);
        active_d       = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        line_start_d   = (h_cnt_q == CNT_ZERO);
        frame_start_d  = line_start_d && (v_cnt_q == CNT_ZERO);
        vblank_start_d = line_start_d && (v_cnt_q == V_ACT_END);
    end

    // Priority: reset, then idle (en low, regardless of pix_en), then tick,
    // then hold. Strobes are cleared on every non-tick clk so they last one
    // clk even when pix_en is a slower divided rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            hsync        <= ~H_SYNC_POL;
            vsync        <= ~V_SYNC_POL;
            video_on     <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else if (!en) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            hsync        <= ~H_SYNC_POL;
            vsync        <= ~V_SYNC_POL;
            video_on     <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else if (pix_en) begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            pixel_x      <= h_cnt_q;
            pixel_y      <= v_cnt_q;
            hsync        <= h_sync_act ? H_SYNC_POL : ~H_SYNC_POL;
            vsync        <= v_sync_act ? V_SYNC_POL : ~V_SYNC_POL;
            video_on     <= active_d;
            line_start   <= line_start_d;
            frame_start  <= frame_start_d;
            vblank_start <= vblank_start_d;
            if (frame_start_d) begin
                frame_count <= frame_count + FRAME_ONE;
            end
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a small raster so whole frames fit in a
// short run: H = 8 active + 2 fp + 3 sync + 3 bp = 16, V = 6 + 1 + 2 + 2 = 11,
// frame = 176 ticks. Hand-derived windows for this geometry:
//   hsync active for x in 10..12, vsync active for y in 7..8,
//   video_on for x<8 && y<6, vblank_start at (0,6).
// A second instance uses inverted sync polarity on the same inputs.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst, en, pix_en;

    logic        hsync, vsync, video_on, line_start, frame_start, vblank_start;
    logic [11:0] pixel_x, pixel_y;
    logic [3:0]  frame_count;

    logic        hsync2, vsync2, video_on2, line_start2, frame_start2, vblank_start2;
    logic [11:0] pixel_x2, pixel_y2;
    logic [3:0]  frame_count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_PIXELS(8), .H_FRONTPORCH(2), .H_SYNCTIME(3), .H_BACKPORCH(3),
        .V_LINES(6), .V_FRONTPORCH(1), .V_SYNCTIME(2), .V_BACKPORCH(2),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_BITS(12), .FRAME_BITS(4)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .en(en),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start),
        .vblank_start(vblank_start), .frame_count(frame_count)
    );

    vga_timing_gen #(
        .H_PIXELS(8), .H_FRONTPORCH(2), .H_SYNCTIME(3), .H_BACKPORCH(3),
        .V_LINES(6), .V_FRONTPORCH(1), .V_SYNCTIME(2), .V_BACKPORCH(2),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_BITS(12), .FRAME_BITS(4)
    ) dut_neg (
        .clk(clk), .rst(rst), .pix_en(pix_en), .en(en),
        .hsync(hsync2), .vsync(vsync2), .video_on(video_on2),
        .pixel_x(pixel_x2), .pixel_y(pixel_y2),
        .line_start(line_start2), .frame_start(frame_start2),
        .vblank_start(vblank_start2), .frame_count(frame_count2)
    );

    typedef struct {
        logic [11:0] x, y;
        logic        hs, vs, vo, ls, fs, vbs;   // hs/vs are "sync active" flags
        logic [3:0]  fc;
    } exp_t;

    exp_t exp_q[$];
    int   ls_cyc[$];
    int   fs_cyc[$];
    int   cyc = 0;

    // bench reference state
    exp_t        m;
    logic [11:0] mh, mv;

    function automatic logic [33:0] pack(input exp_t e);
        return {e.x, e.y, e.hs, e.vs, e.vo, e.ls, e.fs, e.vbs, e.fc};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_period(input string nm, input bit use_fs, input int period);
        int  q[$];
        bit  ok;
        int  bad;
        if (use_fs) q = fs_cyc; else q = ls_cyc;
        ok  = (q.size() >= 2);
        bad = -1;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] - q[i-1] != period) begin
                ok  = 1'b0;
                bad = q[i] - q[i-1];
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: interval %0d over %0d strobes, expected %0d", nm, bad, q.size(), period);
        end
    endtask

    // One clk of stimulus: drive inputs at the negedge, advance the bench
    // model for the coming posedge and queue what the DUT must show after it.
    task automatic step(input logic r, input logic e, input logic p);
        @(negedge clk);
        rst = r; en = e; pix_en = p;
        if (r) begin
            mh = 0; mv = 0;
            m.x = 0; m.y = 0; m.hs = 0; m.vs = 0; m.vo = 0;
            m.ls = 0; m.fs = 0; m.vbs = 0; m.fc = 0;
        end else if (!e) begin
            mh = 0; mv = 0;
            m.x = 0; m.y = 0; m.hs = 0; m.vs = 0; m.vo = 0;
            m.ls = 0; m.fs = 0; m.vbs = 0;
        end else if (p) begin
            m.x   = mh;
            m.y   = mv;
            m.hs  = (mh >= 10) && (mh <= 12);
            m.vs  = (mv >= 7) && (mv <= 8);
            m.vo  = (mh < 8) && (mv < 6);
            m.ls  = (mh == 0);
            m.fs  = (mh == 0) && (mv == 0);
            m.vbs = (mh == 0) && (mv == 6);
            if (m.fs) m.fc = m.fc + 4'd1;
            if (mh == 15) begin
                mh = 0;
                mv = (mv == 10) ? 12'd0 : mv + 12'd1;
            end else begin
                mh = mh + 12'd1;
            end
        end else begin
            m.ls = 0; m.fs = 0; m.vbs = 0;
        end
        exp_q.push_back(m);
    endtask

    // Monitor: every clk the DUT presents a new registered output set.
    initial begin
        exp_t        e;
        logic [33:0] a1, a2;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (line_start) ls_cyc.push_back(cyc);
            if (frame_start) fs_cyc.push_back(cyc);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                a1 = {pixel_x, pixel_y, hsync, vsync, video_on,
                      line_start, frame_start, vblank_start, frame_count};
                a2 = {pixel_x2, pixel_y2, ~hsync2, ~vsync2, video_on2,
                      line_start2, frame_start2, vblank_start2, frame_count2};
                check("raster_pos_pol", 64'(a1), 64'(pack(e)));
                check("raster_neg_pol", 64'(a2), 64'(pack(e)));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fc_hold;
        int         guard;
        rst = 1'b1; en = 1'b0; pix_en = 1'b0;
        mh = 0; mv = 0;
        m.x = 0; m.y = 0; m.hs = 0; m.vs = 0; m.vo = 0;
        m.ls = 0; m.fs = 0; m.vbs = 0; m.fc = 0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Full-rate run from reset: first tick shows (0,0) with both strobes.
        ls_cyc.delete(); fs_cyc.delete();
        step(1'b0, 1'b1, 1'b1);
        @(posedge clk); #2;
        check("first_output",
              64'({pixel_x, pixel_y, video_on, frame_start, line_start, hsync, vsync, frame_count}),
              64'({12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1}));
        for (int i = 1; i < 16 * 176; i++) step(1'b0, 1'b1, 1'b1);
        @(posedge clk); #2;
        check("frame_count_wrap", 64'(frame_count), 64'd0);
        check_period("line_period_full", 1'b0, 16);
        check_period("frame_period_full", 1'b1, 176);

        // Divided pixel rate: one tick every 4 clks.
        ls_cyc.delete();
        for (int i = 0; i < 400; i++) step(1'b0, 1'b1, (i % 4) == 0);
        check_period("line_period_div4", 1'b0, 64);

        // Idle interruption at (5,3).
        guard = 0;
        while (!(m.x == 5 && m.y == 3) && guard < 1000) begin
            step(1'b0, 1'b1, 1'b1);
            guard++;
        end
        check("reach_5_3", 64'(guard < 1000), 64'd1);
        fc_hold = m.fc;
        step(1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("idle_outputs",
              64'({pixel_x, pixel_y, video_on, line_start, hsync, vsync, frame_count}),
              64'({12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, fc_hold}));
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        @(posedge clk); #2;
        check("restart_after_idle",
              64'({pixel_x, pixel_y, frame_start, line_start, frame_count}),
              64'({12'd0, 12'd0, 1'b1, 1'b1, fc_hold + 4'd1}));
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b1);

        // Async reset interruption at (5,3).
        guard = 0;
        while (!(m.x == 5 && m.y == 3) && guard < 1000) begin
            step(1'b0, 1'b1, 1'b1);
            guard++;
        end
        step(1'b1, 1'b1, 1'b1);
        #1;
        check("async_reset_immediate",
              64'({pixel_x, pixel_y, video_on, hsync, vsync, hsync2, vsync2, frame_count}),
              64'({12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0}));
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b1);

        @(posedge clk); #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
